tdm_demux: RTL

Time-division demultiplexer: the receive end of the team's select/mux path. A serial bit stream carries CHANNELS one-bit slots per frame, with a frame-sync marker on slot 0. The block locks to the frame, distributes each slot bit to its own output lane, and updates all lanes together once a full frame is captured. It sits behind the chip's dedicated inputs and drives parallel output lanes in the same top-level design as the 2:1 select logic.

---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_demux_if.sv | 30 +++
 rtl/tdm_demux_slot_ctr.sv | 47 ++++
 rtl/tdm_demux.sv | 110 +++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM state encoding,
// channel-count limits and the slot-counter width helper.
package tdm_pkg;

    localparam int CHANNELS_DEF = 8;
    localparam int CHANNELS_MIN = 2;
    localparam int CHANNELS_MAX = 8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    // Width of the slot counter; never narrower than one bit.
    function automatic int slot_width(input int ch);
        return (ch <= 2) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Bus bundle between the serial TDM source and the demultiplexer.
//
// Handshake: there is no backpressure. en is a one-cycle strobe that
// qualifies din/fsync; the demux must accept every strobed bit. The demux
// side presents frame_valid and sync_err as one-cycle pulses, and ch_out
// and locked as levels. dbg_state mirrors the FSM state register.
interface tdm_demux_if
    import tdm_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF
);
    logic                en;
    logic                din;
    logic                fsync;
    logic [CHANNELS-1:0] ch_out;
    logic                frame_valid;
    logic                locked;
    logic                sync_err;
    logic                dbg_state;

    modport master (
        output en, din, fsync,
        input  ch_out, frame_valid, locked, sync_err, dbg_state
    );

    modport slave (
        input  en, din, fsync,
        output ch_out, frame_valid, locked, sync_err, dbg_state
    );
endinterface

// File: rtl/tdm_demux_slot_ctr.sv
// Slot counter for the TDM demux: tracks which slot the next strobed bit
// belongs to and flags the last slot of the frame.
module tdm_demux_slot_ctr
    import tdm_pkg::*;
#(
    parameter  int CHANNELS = CHANNELS_DEF,
    localparam int SW       = slot_width(CHANNELS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          load1_i,
    input  logic          advance_i,
    output logic [SW-1:0] slot_o,
    output logic          last_o
);
    localparam logic [SW-1:0] SLOT_LAST = SW'(CHANNELS - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

    logic [SW-1:0] slot_q;
    logic [SW-1:0] slot_d;

    // Next slot: clear wins over load-1, load-1 over advance; advance wraps.
    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d = '0;
        end else if (load1_i) begin
            slot_d = SLOT_ONE;
        end else if (advance_i) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_ONE;
        end
    end

    // Slot register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;
    assign last_o = (slot_q == SLOT_LAST);

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: locks to the frame marker on slot 0, collects one
// bit per slot into a shadow register and updates all output lanes at
// once when the final slot of a frame arrives.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    tdm_demux_if.slave  bus
);
    localparam int SW = slot_width(CHANNELS);

    localparam logic [0:0] ST_HUNT   = HUNT;
    localparam logic [0:0] ST_LOCKED = LOCKED;

    logic [0:0]          state_q, state_d;
    logic [CHANNELS-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0] ch_out_q, ch_out_d;
    logic                fv_q, fv_d;
    logic                err_q, err_d;
    logic                locked_q, locked_d;

    logic                ctr_clear;
    logic                ctr_load1;
    logic                ctr_advance;
    logic [SW-1:0]       slot;
    logic                slot_last;

    tdm_demux_slot_ctr #(
        .CHANNELS (CHANNELS)
    ) u_slot_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (ctr_clear),
        .load1_i   (ctr_load1),
        .advance_i (ctr_advance),
        .slot_o    (slot),
        .last_o    (slot_last)
    );

    // Framing FSM plus shadow/lane capture; only strobed cycles do work.
    // A marker on the last slot is treated as misplaced, so the fsync
    // branch is checked before the frame-completion branch.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        ch_out_d    = ch_out_q;
        fv_d        = 1'b0;
        err_d       = 1'b0;
        ctr_clear   = 1'b0;
        ctr_load1   = 1'b0;
        ctr_advance = 1'b0;

        if (bus.en) begin
            if (bus.fsync) begin
                // Start of frame; a nonzero slot means the old frame was cut short.
                shadow_d[0] = bus.din;
                ctr_load1   = 1'b1;
                state_d     = ST_LOCKED;
                if (state_q == ST_LOCKED && slot != '0) begin
                    err_d = 1'b1;
                end
            end else if (state_q == ST_LOCKED) begin
                if (slot == '0) begin
                    // Expected a marker here: drop lock and hunt again.
                    err_d     = 1'b1;
                    state_d   = ST_HUNT;
                    ctr_clear = 1'b1;
                end else begin
                    shadow_d[slot] = bus.din;
                    ctr_advance    = 1'b1;
                    if (slot_last) begin
                        ch_out_d = shadow_d;
                        fv_d     = 1'b1;
                    end
                end
            end
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers; reset dominates the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            shadow_q <= '0;
            ch_out_q <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            ch_out_q <= ch_out_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign bus.ch_out      = ch_out_q;
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = err_q;
    assign bus.locked      = locked_q;
    assign bus.dbg_state   = state_q;

endmodule
